// File: rtl/lstm_seq_driver_if.sv
// lstm_seq_driver_if
//   Groups the streaming and cell-facing signals of lstm_seq_driver.
//   x_*    : input sample stream (valid/ready), upstream -> driver
//   h_*    : hidden-state output stream (valid/ready), driver -> downstream
//   cell_* : operands presented to the LSTM cell and its results
//   Modports: slave = the sequencing block, master = its environment.
interface lstm_seq_driver_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  x_valid;
  logic                  x_ready;
  logic [DATA_WIDTH-1:0] x_data;
  logic                  h_valid;
  logic                  h_ready;
  logic [DATA_WIDTH-1:0] h_data;
  logic                  h_last;
  logic [DATA_WIDTH-1:0] cell_x;
  logic [DATA_WIDTH-1:0] cell_h;
  logic [DATA_WIDTH-1:0] cell_c;
  logic [DATA_WIDTH-1:0] cell_c_out;
  logic [DATA_WIDTH-1:0] cell_h_out;

  modport slave (
    input  x_valid, x_data, h_ready, cell_c_out, cell_h_out,
    output x_ready, h_valid, h_data, h_last, cell_x, cell_h, cell_c
  );

  modport master (
    output x_valid, x_data, h_ready, cell_c_out, cell_h_out,
    input  x_ready, h_valid, h_data, h_last, cell_x, cell_h, cell_c
  );
endinterface

// File: rtl/lstm_seq_driver.sv
// lstm_seq_driver
//   Sequencing stage in front of a combinational LSTM cell. For each of
//   seq_len timesteps it accepts one sample X, presents {X, h, c} to the
//   cell for CELL_LATENCY cycles, captures the cell results as the new
//   (h, c) and emits h downstream. State starts from zero on every run.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, seq_len  : run request and its length (sampled in IDLE only)
//   busy, done      : run in progress / one-cycle end-of-run pulse
//   h_final,c_final : state after the last step, held until next start
//   io (slave)      : x stream, h stream and cell operand/result signals
module lstm_seq_driver #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRACT_WIDTH  = 8,
  parameter int CELL_LATENCY = 1,
  parameter int SEQ_LEN_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SEQ_LEN_W-1:0]  seq_len,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] h_final,
  output logic [DATA_WIDTH-1:0] c_final,
  lstm_seq_driver_if.slave      io
);

  // Values are only carried, never computed on, so the fixed-point format
  // matters only as a sanity bound on the parameters.
  if (CELL_LATENCY < 1 || CELL_LATENCY > 15) begin : g_bad_latency
    $error("lstm_seq_driver: CELL_LATENCY must be within 1..15");
  end
  if (FRACT_WIDTH < 0 || FRACT_WIDTH > DATA_WIDTH) begin : g_bad_fract
    $error("lstm_seq_driver: FRACT_WIDTH must be within 0..DATA_WIDTH");
  end

  localparam logic [3:0] LAT_LOAD = 4'(CELL_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_X,
    CALC,
    EMIT,
    DONE
  } state_t;

  state_t                state, state_next;
  logic [SEQ_LEN_W-1:0]  len_reg;
  logic [SEQ_LEN_W-1:0]  step_cnt;
  logic [3:0]            lat_cnt;
  logic [DATA_WIDTH-1:0] x_reg;
  logic [DATA_WIDTH-1:0] h_reg;
  logic [DATA_WIDTH-1:0] c_reg;
  // Snapshots of h/c taken when the step starts, so the cell operands stay
  // frozen after h_reg/c_reg are overwritten at the end of CALC.
  logic [DATA_WIDTH-1:0] cell_h_reg;
  logic [DATA_WIDTH-1:0] cell_c_reg;
  logic                  is_last;

  assign is_last = (step_cnt == len_reg - SEQ_LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b1;
    done        = 1'b0;
    io.x_ready  = 1'b0;
    io.h_valid  = 1'b0;
    io.h_last   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (seq_len != '0) ? WAIT_X : DONE;
        end
      end
      WAIT_X: begin
        io.x_ready = 1'b1;
        if (io.x_valid) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (lat_cnt == 4'd0) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        io.h_valid = 1'b1;
        io.h_last  = is_last;
        if (io.h_ready) begin
          state_next = is_last ? DONE : WAIT_X;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: sample latch, recurrent state, step/latency counters and the
  // final-state registers published on the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg    <= '0;
      step_cnt   <= '0;
      lat_cnt    <= '0;
      x_reg      <= '0;
      h_reg      <= '0;
      c_reg      <= '0;
      cell_h_reg <= '0;
      cell_c_reg <= '0;
      h_final    <= '0;
      c_final    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_reg  <= seq_len;
            step_cnt <= '0;
            h_reg    <= '0;
            c_reg    <= '0;
          end
        end
        WAIT_X: begin
          if (io.x_valid) begin
            x_reg      <= io.x_data;
            cell_h_reg <= h_reg;
            cell_c_reg <= c_reg;
            lat_cnt    <= LAT_LOAD;
          end
        end
        CALC: begin
          if (lat_cnt == 4'd0) begin
            h_reg <= io.cell_h_out;
            c_reg <= io.cell_c_out;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        EMIT: begin
          if (io.h_ready) begin
            step_cnt <= step_cnt + SEQ_LEN_W'(1);
          end
        end
        DONE: begin
          h_final <= h_reg;
          c_final <= c_reg;
        end
        default: begin
        end
      endcase
    end
  end

  assign io.cell_x = x_reg;
  assign io.cell_h = cell_h_reg;
  assign io.cell_c = cell_c_reg;
  assign io.h_data = h_reg;

endmodule

// File: tb/tb_lstm_seq_driver.sv
// tb_lstm_seq_driver
//   Two driver instances (cell latency 1 and 4) share one stimulus bus; only
//   the selected instance is started, the other ignores x/h traffic. A stub
//   cell returns a known function of its operands, but outputs garbage in
//   every CALC cycle except the last one so premature sampling is visible.
module tb_lstm_seq_driver;
  localparam int DW    = 16;
  localparam int LW    = 8;
  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] seq_len = '0;
  logic          x_valid = 1'b0;
  logic [DW-1:0] x_data = '0;
  logic          h_ready = 1'b0;
  logic [DW-1:0] stub_h, stub_c;

  int sel = 0;
  int mode = 0;
  int cur_lat;
  bit mon_en = 1'b0;
  bit fast_mode = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lstm_seq_driver_if #(.DATA_WIDTH(DW)) if_a ();
  lstm_seq_driver_if #(.DATA_WIDTH(DW)) if_b ();

  logic          busy_a, done_a, busy_b, done_b;
  logic [DW-1:0] hf_a, cf_a, hf_b, cf_b;
  logic          start_a, start_b;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);

  assign if_a.x_valid = x_valid;      assign if_b.x_valid = x_valid;
  assign if_a.x_data = x_data;        assign if_b.x_data = x_data;
  assign if_a.h_ready = h_ready;      assign if_b.h_ready = h_ready;
  assign if_a.cell_h_out = stub_h;    assign if_b.cell_h_out = stub_h;
  assign if_a.cell_c_out = stub_c;    assign if_b.cell_c_out = stub_c;

  lstm_seq_driver #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .CELL_LATENCY(LAT_A), .SEQ_LEN_W(LW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .seq_len(seq_len), .busy(busy_a), .done(done_a),
    .h_final(hf_a), .c_final(cf_a), .io(if_a)
  );

  lstm_seq_driver #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .CELL_LATENCY(LAT_B), .SEQ_LEN_W(LW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .seq_len(seq_len), .busy(busy_b), .done(done_b),
    .h_final(hf_b), .c_final(cf_b), .io(if_b)
  );

  logic          cur_busy, cur_done, cur_x_ready, cur_h_valid, cur_h_last;
  logic [DW-1:0] cur_h_data, cur_hf, cur_cf, cur_cx, cur_ch, cur_cc;

  assign cur_lat     = (sel == 1) ? LAT_B : LAT_A;
  assign cur_busy    = (sel == 1) ? busy_b : busy_a;
  assign cur_done    = (sel == 1) ? done_b : done_a;
  assign cur_x_ready = (sel == 1) ? if_b.x_ready : if_a.x_ready;
  assign cur_h_valid = (sel == 1) ? if_b.h_valid : if_a.h_valid;
  assign cur_h_last  = (sel == 1) ? if_b.h_last : if_a.h_last;
  assign cur_h_data  = (sel == 1) ? if_b.h_data : if_a.h_data;
  assign cur_hf      = (sel == 1) ? hf_b : hf_a;
  assign cur_cf      = (sel == 1) ? cf_b : cf_a;
  assign cur_cx      = (sel == 1) ? if_b.cell_x : if_a.cell_x;
  assign cur_ch      = (sel == 1) ? if_b.cell_h : if_a.cell_h;
  assign cur_cc      = (sel == 1) ? if_b.cell_c : if_a.cell_c;

  // Stub cell behaviour: 0 = constant, 1 = accumulate, 2 = mixing function.
  function automatic logic [31:0] cell_fn(input int m, input logic [DW-1:0] x, h, c);
    case (m)
      0:       return {16'h0080, 16'h0100};
      1:       return {16'(h + x), 16'(c + 16'h0100)};
      default: return {16'((h ^ x) + 16'h0013), 16'(c - x)};
    endcase
  endfunction

  // Tracks where the selected instance should be inside CALC, from the
  // handshake timing alone (x accepted at edge t -> CALC for CELL_LATENCY).
  bit in_calc = 1'b0;
  int calc_age = 0;
  always @(posedge clk) begin
    if (rst) begin
      in_calc  <= 1'b0;
      calc_age <= 0;
    end else if (x_valid && cur_x_ready) begin
      in_calc  <= 1'b1;
      calc_age <= 0;
    end else if (in_calc) begin
      if (calc_age == cur_lat - 1) in_calc <= 1'b0;
      else calc_age <= calc_age + 1;
    end
  end

  always_comb begin
    {stub_h, stub_c} = cell_fn(mode, cur_cx, cur_ch, cur_cc);
    if (mode != 0 && !(in_calc && calc_age == cur_lat - 1)) begin
      stub_h = stub_h ^ 16'hA5A5;
      stub_c = ~stub_c;
    end
  end

  logic [47:0] cell_q[$];
  logic [16:0] beat_q[$];
  logic [31:0] fin_q[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=expired required=event", name);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_ctrl"}, {cur_busy, cur_done, cur_x_ready, cur_h_valid, cur_h_last}, 64'd0);
    checkOutput({tag, "_data"}, {cur_h_data, cur_hf, cur_cf, cur_cx}, 64'd0);
    checkOutput({tag, "_cell"}, {cur_ch, cur_cc}, 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever the selected instance presents
  // something, and checks stability/timing rules along the way.
  bit          prev_hv = 1'b0, prev_hr = 1'b0, prev_hl = 1'b0, fin_pend = 1'b0;
  logic [DW-1:0] prev_hd = '0;
  logic [47:0] cell_first = '0;
  logic [31:0] fin_exp = '0;
  int hs_now = 0, last_now = 0, start_now = 0, start_len = 0, last_hhs = -100;

  always @(negedge clk) begin
    int now;
    logic [47:0] ce;
    logic [16:0] be;
    now = cyc + 1;
    if (!mon_en) begin
      prev_hv  = 1'b0;
      fin_pend = 1'b0;
      last_hhs = -100;
    end else begin
      if (in_calc) begin
        if (calc_age == 0) begin
          if (cell_q.size() == 0) reportFail("cell_q_underflow");
          else begin
            ce = cell_q.pop_front();
            checkOutput("cell_inputs", {cur_cx, cur_ch, cur_cc}, ce);
            cell_first = {cur_cx, cur_ch, cur_cc};
          end
        end else begin
          checkOutput("cell_stable", {cur_cx, cur_ch, cur_cc}, cell_first);
        end
      end
      if (prev_hv && !prev_hr) begin
        checkOutput("bp_hold", {cur_h_valid, cur_h_data, cur_h_last}, {1'b1, prev_hd, prev_hl});
        checkOutput("bp_x_ready", cur_x_ready, 0);
      end
      if (cur_h_valid && !prev_hv) checkOutput("h_valid_latency", now - hs_now, cur_lat + 1);
      if (x_valid && cur_x_ready) hs_now = now;
      if (cur_h_valid && h_ready) begin
        if (beat_q.size() == 0) reportFail("unexpected_beat");
        else begin
          be = beat_q.pop_front();
          checkOutput("h_beat", {cur_h_data, cur_h_last}, be);
        end
        if (fast_mode && last_hhs >= 0) checkOutput("step_period", now - last_hhs, cur_lat + 2);
        last_hhs = now;
        if (cur_h_last) last_now = now;
      end
      if (start && !cur_busy) begin
        start_now = now;
        start_len = int'(seq_len);
        last_hhs  = -100;
      end
      if (fin_pend) begin
        checkOutput("final_state", {cur_hf, cur_cf}, fin_exp);
        checkOutput("idle_after_done", cur_busy, 0);
        fin_pend = 1'b0;
      end
      if (cur_done) begin
        if (fin_q.size() == 0) reportFail("unexpected_done");
        else begin
          fin_exp  = fin_q.pop_front();
          fin_pend = 1'b1;
          checkOutput("done_busy", cur_busy, 1);
          checkOutput("done_timing", now - ((start_len == 0) ? start_now : last_now), 1);
        end
      end
    end
    prev_hv = cur_h_valid;
    prev_hr = h_ready;
    prev_hd = cur_h_data;
    prev_hl = cur_h_last;
  end

  task automatic abortRun();
    rst     = 1'b1;
    mon_en  = 1'b0;
    x_valid = 1'b0;
    start   = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cell_q.delete();
    beat_q.delete();
    fin_q.delete();
    checkIdleZero("abort");
    mon_en = 1'b1;
  endtask

  // One run: build the expected sequence from the stub's rules, then drive
  // start, the x stream and h_ready until the run ends (or aborts).
  // xpat: 0 random, 1 = (i+1)*0x100, 2 = constant 0x100.
  task automatic applyStimulus(input int m, input int len, input int xpat, input bit fast,
                               input int bp, input bit pulse, input bit early, input int abort_at);
    logic [DW-1:0] xs[$];
    logic [DW-1:0] h, c;
    int idx, hsc, bp_left, budget;
    bit hs;
    for (int i = 0; i < len; i++) begin
      case (xpat)
        1:       xs.push_back(16'((i + 1) * 256));
        2:       xs.push_back(16'h0100);
        default: xs.push_back(16'($urandom));
      endcase
    end
    h = '0;
    c = '0;
    for (int i = 0; i < len; i++) begin
      cell_q.push_back({xs[i], h, c});
      {h, c} = cell_fn(m, xs[i], h, c);
      beat_q.push_back({h, (i == len - 1)});
    end
    fin_q.push_back({h, c});
    mode      = m;
    fast_mode = fast;
    start     = 1'b1;
    seq_len   = LW'(len);
    x_valid   = 1'b0;
    h_ready   = fast;
    @(posedge clk); #1;
    if (early) begin
      checkOutput("start_in_done_ignored", cur_busy, 0);
      @(posedge clk); #1;
    end
    budget = 8;
    while (!cur_busy && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!cur_busy) begin
      reportFail("start_accept_timeout");
      abortRun();
      return;
    end
    start = 1'b0;
    if (len == 0) checkOutput("len0_no_transfer", {cur_x_ready, cur_h_valid}, 0);
    idx = 0;
    hsc = 0;
    bp_left = bp;
    budget = 600;
    while (!cur_done) begin
      if (budget == 0) begin
        reportFail("run_timeout");
        abortRun();
        return;
      end
      x_valid = (idx < len) && (fast || $urandom_range(3) != 0);
      x_data  = x_valid ? xs[idx] : 16'($urandom);
      if (cur_h_valid && bp_left > 0) begin
        h_ready = 1'b0;
        bp_left--;
      end else begin
        h_ready = fast || ($urandom_range(2) != 0);
      end
      if (pulse) begin
        start   = 1'($urandom_range(1));
        seq_len = LW'($urandom);
      end
      hs = x_valid && cur_x_ready;
      @(posedge clk); #1;
      budget--;
      if (hs) begin
        idx++;
        hsc++;
        if (hsc == abort_at) begin
          abortRun();
          return;
        end
      end
    end
    start   = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic randomRuns(input int n);
    bit f;
    for (int r = 0; r < n; r++) begin
      f = 1'($urandom_range(1));
      applyStimulus($urandom_range(1, 2), $urandom_range(1, 8), 0, f,
                    f ? 0 : $urandom_range(0, 4), 1'($urandom_range(1)), 1'b0, 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sel = 1;
    checkIdleZero("reset_b");
    sel = 0;
    checkIdleZero("reset_a");
    mon_en = 1'b1;

    $display("[TB] latency 1 instance");
    applyStimulus(0, 3, 1, 1'b1, 0, 1'b0, 1'b0, 0);
    applyStimulus(1, 4, 2, 1'b1, 0, 1'b0, 1'b0, 0);
    applyStimulus(2, 3, 0, 1'b0, 5, 1'b1, 1'b0, 0);
    applyStimulus(0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    applyStimulus(2, 2, 0, 1'b0, 0, 1'b0, 1'b1, 0);
    applyStimulus(1, 5, 2, 1'b1, 0, 1'b0, 1'b0, 2);
    applyStimulus(1, 5, 2, 1'b1, 0, 1'b0, 1'b0, 0);
    randomRuns(6);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] latency 4 instance");
    sel = 1;
    applyStimulus(2, 4, 0, 1'b1, 0, 1'b0, 1'b0, 0);
    applyStimulus(1, 3, 2, 1'b0, 5, 1'b1, 1'b0, 0);
    applyStimulus(0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 0);
    applyStimulus(2, 4, 0, 1'b1, 0, 1'b0, 1'b0, 3);
    randomRuns(5);
    repeat (3) @(posedge clk);
    #1;

    checkOutput("beat_q_drained", beat_q.size(), 0);
    checkOutput("cell_q_drained", cell_q.size(), 0);
    checkOutput("fin_q_drained", fin_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/lstm_seq_driver.md
# lstm_seq_driver

Sequencing stage directly upstream of the LSTM cell. It accepts a stream of Q8.8 input samples over a valid/ready handshake and holds the recurrent state registers (h, c). It presents {X, h, c} to the cell for a fixed number of cycles, captures the cell's c_out/h_out as the next state, and emits each step's h on an output stream. One run processes one sequence of programmable length, starting from zero state.

## Interface
- DATA_WIDTH, 16, sample/state width (signed fixed point)
- FRACT_WIDTH, 8, fractional bits (Q8.8 at defaults); block does no arithmetic on values, only carries them
- CELL_LATENCY, 1, cycles the cell inputs are held before outputs are sampled; legal range 1..15
- SEQ_LEN_W, 8, width of sequence-length field

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sequence (sampled only in IDLE)
- seq_len  in  SEQ_LEN_W  number of timesteps; latched on accepted start
- busy  out  1  high from accepted start until the DONE cycle, inclusive
- done  out  1  one-cycle pulse at end of sequence
- x_valid  in  1  input sample valid
- x_ready  out  1  block can accept sample
- x_data  in  DATA_WIDTH  input sample X
- cell_x, cell_h, cell_c  out  DATA_WIDTH each  to cell X, h_in, c_in
- cell_c_out, cell_h_out  in  DATA_WIDTH each  from cell c_out, h_out
- h_valid  out  1  output sample valid
- h_ready  in  1  downstream accepts output
- h_data  out  DATA_WIDTH  hidden state of current step
- h_last  out  1  marks the final step of the sequence
- h_final, c_final  out  DATA_WIDTH each  state after last step; held until next accepted start

## Operation
- States: IDLE, WAIT_X, CALC, EMIT, DONE.
- IDLE: x_ready=0, h_valid=0. On start=1:
  - Latch seq_len into len_reg; clear h_reg, c_reg, step_cnt to 0.
  - If seq_len≠0, go to WAIT_X.
  - If seq_len=0, go to DONE with no x/h transfers.
- WAIT_X: x_ready=1. On x_valid&x_ready, latch x_reg=x_data, load lat_cnt=CELL_LATENCY-1, go to CALC.
- CALC: cell_x=x_reg, cell_h=h_reg, cell_c=c_reg, all stable for the whole state. lat_cnt decrements each cycle. In the cycle where lat_cnt=0:
  - Sample h_reg←cell_h_out and c_reg←cell_c_out.
  - Go to EMIT.
- EMIT: h_valid=1, h_data=h_reg, h_last=(step_cnt==len_reg-1). On h_ready:
  - step_cnt increments.
  - If h_last, go to DONE; otherwise go to WAIT_X.
- DONE: done=1 and busy=1 for exactly this cycle. Update h_final=h_reg, c_final=c_reg. Go to IDLE.
- cell_* outputs hold their last values outside CALC; the cell is combinational, so only the values during CALC matter.
- start is ignored outside IDLE. x_valid is ignored outside WAIT_X. h_ready is ignored outside EMIT.
- seq_len is an unsigned value. Maximum is 2^SEQ_LEN_W-1 steps. step_cnt is SEQ_LEN_W wide and never wraps in a legal run.

## Timing
- Reset values: state=IDLE. busy, done, x_ready, h_valid, h_last = 0. h_data, h_final, c_final, cell_x, cell_h, cell_c = 0. Internal h_reg, c_reg, x_reg, step_cnt, len_reg = 0.
- rst asserted in any state aborts the run next edge: no done pulse, and h_final/c_final are cleared to 0.
- Start accepted at edge t → busy=1 and x_ready=1 from t+1.
- x handshake at edge t → CALC for cycles t+1..t+CELL_LATENCY → h_valid=1 from t+CELL_LATENCY+1.
- Minimum step period is CELL_LATENCY+2 cycles (WAIT_X 1, CALC CELL_LATENCY, EMIT 1), reached when x_valid and h_ready are held high.
- h_valid/h_data/h_last stay stable while h_ready=0. Backpressure may last indefinitely.
- x_ready is combinational from state only; it never depends on x_valid.
- seq_len=0: start at edge t → DONE at t+1 (done=1, busy=1) → IDLE at t+2.
- Last handshake at edge t (h_last=1) → done=1 during cycle t+1 → h_final/c_final valid from t+2.
- start asserted in the DONE cycle is ignored. It is accepted in IDLE at the earliest one cycle later.

## Test plan
- Constant cell stub (cell_h_out=0x0080, cell_c_out=0x0100), CELL_LATENCY=1, seq_len=3, x=0x0100,0x0200,0x0300 with x_valid and h_ready always high:
  - Three h_valid beats of 0x0080, h_last only on the third.
  - Step period 3 cycles.
  - done one cycle after the last beat; h_final=0x0080, c_final=0x0100.
- Recurrence check with stub h_out=h_in+x, c_out=c_in+0x0100, seq_len=4, x=0x0100 each step:
  - h_data=0x0100,0x0200,0x0300,0x0400.
  - c_final=0x0400.
  - cell_h at the first CALC is 0 (state cleared at start).
- Backpressure: hold h_ready=0 for 5 cycles during EMIT:
  - h_data/h_last stable.
  - x_ready=0 throughout.
  - No further cell sampling.
- CELL_LATENCY=4:
  - cell_* stable for exactly 4 cycles.
  - h_valid rises 5 cycles after the x handshake.
  - Outputs sampled only on the 4th CALC cycle (stub changes value mid-CALC; the last value is captured).
- seq_len=0 → done at t+1, no x_ready or h_valid; start pulsed while busy → ignored, run length unchanged.
- rst asserted mid-CALC of step 2 of 5:
  - Next cycle: IDLE, all outputs 0, no done.
  - A fresh start then runs a full sequence from zero state.
